// File: rtl/eth_tx_serializer.sv
// eth_tx_serializer: drains one frame from the TX byte FIFO (payload plus the
// 4 trailing CRC bytes) and drives it onto the MII transmit pins. The frame is
// sent as preamble, SFD, payload and CRC nibbles, low nibble first, followed by
// the inter-frame gap.
// Optional build macro ETH_TX_STATS_EN adds good-frame and good-byte counters.
//
// Read-ahead scheme: FIFO data arrives one cycle after the read strobe. A byte
// is therefore fetched two bytes before it is sent:
//  - byte 0 is read on accept;
//  - byte 1 is read on the SFD 'D' nibble;
//  - byte k+2 is read on the high nibble of byte k.
// r_nxt holds the prefetched byte and r_hi holds the high nibble in flight.
module eth_tx_serializer #(
  parameter int PREAMBLE_BYTES = 7,
  parameter int IFG_CYCLES     = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] i_word_count,
  input  logic        i_word_count_ready,
  output logic        o_word_count_ack,
  input  logic        i_fifo_empty,
  output logic        o_fifo_rd,
  input  logic [7:0]  i_fifo_data,
  output logic [3:0]  o_txd,
  output logic        o_tx_en,
  output logic        o_tx_er,
  output logic        o_underrun
`ifdef ETH_TX_STATS_EN
  ,
  output logic [15:0] o_frame_count,
  output logic [31:0] o_byte_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_SFD      = 3'd2,
    S_DATA     = 3'd3,
    S_IFG      = 3'd4
  } state_t;

  // The state names what the next clock edge puts on the wire.
  localparam logic [7:0] PRE_LAST = 8'(2 * PREAMBLE_BYTES - 1);
  localparam logic [7:0] IFG_LAST = 8'(IFG_CYCLES - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [11:0] r_bytes_left;
  logic [11:0] r_rd_left;
  logic        r_phase;
  logic [7:0]  r_nxt;
  logic [3:0]  r_hi;
  logic        r_data_vld;
  logic        r_ack;
  logic        r_fifo_rd;
  logic [3:0]  r_txd;
  logic        r_tx_en;
  logic        r_tx_er;
  logic        r_underrun;

  logic        w_accept;
  logic [11:0] w_total;

  assign w_accept = (r_state == S_IDLE) && i_word_count_ready && !r_ack;
  assign w_total  = {1'b0, i_word_count} + 12'd4;

  assign o_word_count_ack = r_ack;
  assign o_fifo_rd        = r_fifo_rd;
  assign o_txd            = r_txd;
  assign o_tx_en          = r_tx_en;
  assign o_tx_er          = r_tx_er;
  assign o_underrun       = r_underrun;

  // Frame FSM: handshake, FIFO prefetch, nibble serialisation and gap timing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 8'd0;
      r_bytes_left <= 12'd0;
      r_rd_left    <= 12'd0;
      r_phase      <= 1'b0;
      r_nxt        <= 8'd0;
      r_hi         <= 4'd0;
      r_data_vld   <= 1'b0;
      r_ack        <= 1'b0;
      r_fifo_rd    <= 1'b0;
      r_txd        <= 4'd0;
      r_tx_en      <= 1'b0;
      r_tx_er      <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_fifo_rd  <= 1'b0;
      r_tx_er    <= 1'b0;
      r_data_vld <= r_fifo_rd;
      if (r_data_vld) begin
        r_nxt <= i_fifo_data;
      end
      // The ack release only watches ready, whatever the transmitter is doing.
      if (r_ack && !i_word_count_ready) begin
        r_ack <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          r_tx_en <= 1'b0;
          r_txd   <= 4'd0;
          if (w_accept) begin
            r_ack        <= 1'b1;
            r_bytes_left <= w_total;
            r_cnt        <= 8'd1;
            r_phase      <= 1'b0;
            if (i_fifo_empty) begin
              r_underrun <= 1'b1;
              r_tx_en    <= 1'b1;
              r_tx_er    <= 1'b1;
              r_cnt      <= 8'd0;
              r_state    <= S_IFG;
            end else begin
              r_underrun <= 1'b0;
              r_tx_en    <= 1'b1;
              r_txd      <= 4'h5;
              r_fifo_rd  <= 1'b1;
              r_rd_left  <= w_total - 12'd1;
              r_state    <= S_PREAMBLE;
            end
          end
        end

        S_PREAMBLE: begin
          r_tx_en <= 1'b1;
          r_txd   <= 4'h5;
          if (r_cnt == PRE_LAST) begin
            r_cnt   <= 8'd0;
            r_state <= S_SFD;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        S_SFD: begin
          r_tx_en <= 1'b1;
          if (r_cnt == 8'd0) begin
            r_txd <= 4'h5;
            r_cnt <= 8'd1;
          end else if (r_rd_left != 12'd0 && i_fifo_empty) begin
            r_underrun <= 1'b1;
            r_tx_er    <= 1'b1;
            r_txd      <= 4'd0;
            r_cnt      <= 8'd0;
            r_state    <= S_IFG;
          end else begin
            r_txd   <= 4'hD;
            r_cnt   <= 8'd0;
            r_phase <= 1'b0;
            r_state <= S_DATA;
            if (r_rd_left != 12'd0) begin
              r_fifo_rd <= 1'b1;
              r_rd_left <= r_rd_left - 12'd1;
            end
          end
        end

        S_DATA: begin
          r_tx_en <= 1'b1;
          if (!r_phase) begin
            r_txd   <= r_nxt[3:0];
            r_hi    <= r_nxt[7:4];
            r_phase <= 1'b1;
          end else if (r_bytes_left == 12'd1) begin
            r_txd        <= r_hi;
            r_bytes_left <= 12'd0;
            r_phase      <= 1'b0;
            r_cnt        <= 8'd0;
            r_state      <= S_IFG;
          end else if (r_rd_left != 12'd0 && i_fifo_empty) begin
            // Underrun: the error cycle replaces this high nibble.
            r_underrun <= 1'b1;
            r_tx_er    <= 1'b1;
            r_txd      <= 4'd0;
            r_phase    <= 1'b0;
            r_cnt      <= 8'd0;
            r_state    <= S_IFG;
          end else begin
            r_txd        <= r_hi;
            r_bytes_left <= r_bytes_left - 12'd1;
            r_phase      <= 1'b0;
            if (r_rd_left != 12'd0) begin
              r_fifo_rd <= 1'b1;
              r_rd_left <= r_rd_left - 12'd1;
            end
          end
        end

        S_IFG: begin
          r_tx_en <= 1'b0;
          r_txd   <= 4'd0;
          if (r_cnt == IFG_LAST) begin
            r_cnt   <= 8'd0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        default: begin
          r_tx_en <= 1'b0;
          r_txd   <= 4'd0;
          r_cnt   <= 8'd0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ETH_TX_STATS_EN
  logic [15:0] r_frame_count;
  logic [31:0] r_byte_count;
  logic [10:0] r_count;
  logic        w_frame_done;

  // The last CRC nibble leaves on this edge and no underrun cut the frame short.
  assign w_frame_done = (r_state == S_DATA) && r_phase && (r_bytes_left == 12'd1);

  assign o_frame_count = r_frame_count;
  assign o_byte_count  = r_byte_count;

  // Good-frame statistics; both counters wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_count <= 16'd0;
      r_byte_count  <= 32'd0;
      r_count       <= 11'd0;
    end else begin
      if (w_accept) begin
        r_count <= i_word_count;
      end
      if (w_frame_done) begin
        r_frame_count <= r_frame_count + 16'd1;
        r_byte_count  <= r_byte_count + {21'd0, r_count} + 32'd4;
      end
    end
  end
`endif

endmodule

// File: tb/tb_eth_tx_serializer.sv
// Randomised self-checking bench for eth_tx_serializer. The expected MII
// waveform for every frame is built from the frame rules:
//  - 15 nibbles of 5, then D;
//  - the bytes as low/high nibbles;
//  - for an underrun, a single error cycle;
//  - 24 idle cycles.
// The waveform is then compared cycle by cycle on the falling edge.
module tb_eth_tx_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] wc = 11'd0;
  logic        ready = 1'b0;
  logic        ack;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd;
  logic [7:0]  fifo_data = 8'd0;
  logic [3:0]  txd;
  logic        tx_en;
  logic        tx_er;
  logic        underrun;
`ifdef ETH_TX_STATS_EN
  logic [15:0] frame_count;
  logic [31:0] byte_count;
  int          exp_fc = 0;
  longint      exp_bc = 0;
`endif

  eth_tx_serializer dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_word_count       (wc),
    .i_word_count_ready (ready),
    .o_word_count_ack   (ack),
    .i_fifo_empty       (fifo_empty),
    .o_fifo_rd          (fifo_rd),
    .i_fifo_data        (fifo_data),
    .o_txd              (txd),
    .o_tx_en            (tx_en),
    .o_tx_er            (tx_er),
    .o_underrun         (underrun)
`ifdef ETH_TX_STATS_EN
    ,
    .o_frame_count      (frame_count),
    .o_byte_count       (byte_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Behavioural FIFO: data one cycle after a read, empty flag registered.
  logic [7:0] fifo_q[$];
  always @(posedge clk) begin
    if (fifo_rd) begin
      check("rd_nonempty", {31'd0, fifo_q.size() > 0}, 32'd1);
      if (fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Frame bookkeeping.
  logic [7:0] cur_b[$];
  logic [7:0] nxt_b[$];
  int cur_cnt, cur_avail, nxt_cnt, nxt_avail;
  bit last_ur = 1'b0;
  bit exp_en[$];
  bit exp_er[$];
  logic [3:0] exp_txd[$];
  int uidx;

  task automatic push_exp(input bit en, input bit er, input logic [3:0] d);
    exp_en.push_back(en);
    exp_er.push_back(er);
    exp_txd.push_back(d);
  endtask

  task automatic build_exp();
    int total;
    total = cur_cnt + 4;
    exp_en.delete(); exp_er.delete(); exp_txd.delete();
    uidx = -1;
    for (int i = 0; i < 15; i++) push_exp(1'b1, 1'b0, 4'h5);
    push_exp(1'b1, 1'b0, 4'hD);
    if (cur_avail >= total) begin
      for (int b = 0; b < total; b++) begin
        push_exp(1'b1, 1'b0, cur_b[b][3:0]);
        push_exp(1'b1, 1'b0, cur_b[b][7:4]);
      end
    end else begin
      // Byte k+2 is fetched while byte k's high nibble is due.
      for (int b = 0; b < cur_avail - 2; b++) begin
        push_exp(1'b1, 1'b0, cur_b[b][3:0]);
        push_exp(1'b1, 1'b0, cur_b[b][7:4]);
      end
      push_exp(1'b1, 1'b0, cur_b[cur_avail-2][3:0]);
      uidx = exp_en.size();
      push_exp(1'b1, 1'b1, 4'h0);
    end
    for (int i = 0; i < 24; i++) push_exp(1'b0, 1'b0, 4'h0);
  endtask

  task automatic prep_next(input int cnt, input int avail, input bit fixed);
    logic [7:0] t1 [5];
    t1 = '{8'hAB, 8'h11, 8'h22, 8'h33, 8'h44};
    nxt_cnt = cnt;
    nxt_avail = avail;
    nxt_b.delete();
    for (int i = 0; i < cnt + 4; i++) begin
      if (fixed && i < 5) nxt_b.push_back(t1[i]);
      else nxt_b.push_back(8'($urandom));
    end
    for (int i = 0; i < avail; i++) fifo_q.push_back(nxt_b[i]);
  endtask

  task automatic raise_ready();
    repeat (2) @(negedge clk);
    check("underrun_sticky", {31'd0, underrun}, {31'd0, last_ur});
    wc = 11'(nxt_cnt);
    ready = 1'b1;
  endtask

  task automatic run_frame(input int hold, input bit started, input bit chain,
                           input int ch_cnt, input int ch_avail);
    int w, len, rd_cnt;
    bit full;
    cur_cnt = nxt_cnt;
    cur_avail = nxt_avail;
    cur_b = nxt_b;
    full = (cur_avail >= cur_cnt + 4);
    build_exp();
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!started && tx_en !== 1'b1 && w < 40);
    len = (exp_en.size() > hold + 2) ? exp_en.size() : hold + 2;
    rd_cnt = 0;
    for (int i = 0; i < len; i++) begin
      bit e_en, e_er;
      logic [3:0] e_d;
      if (i > 0) @(negedge clk);
      e_en = (i < exp_en.size()) ? exp_en[i] : 1'b0;
      e_er = (i < exp_en.size()) ? exp_er[i] : 1'b0;
      e_d  = (i < exp_en.size()) ? exp_txd[i] : 4'h0;
      check("tx_en", {31'd0, tx_en}, {31'd0, e_en});
      check("tx_er", {31'd0, tx_er}, {31'd0, e_er});
      check("txd", {28'd0, txd}, {28'd0, e_d});
      check("ack", {31'd0, ack}, {31'd0, i < hold});
      check("underrun", {31'd0, underrun}, {31'd0, (uidx >= 0) && (i >= uidx)});
      if (fifo_rd) rd_cnt++;
      if (i == hold - 1) ready = 1'b0;
      if (chain && i == hold + 1) begin
        prep_next(ch_cnt, ch_avail, 1'b0);
        wc = 11'(nxt_cnt);
        ready = 1'b1;
      end
    end
    check("rd_pulses", rd_cnt, full ? cur_cnt + 4 : cur_avail);
    if (!chain) check("fifo_drained", fifo_q.size(), 0);
    last_ur = !full;
`ifdef ETH_TX_STATS_EN
    if (full) begin
      exp_fc++;
      exp_bc += cur_cnt + 4;
    end
    check("frame_count", {16'd0, frame_count}, 32'(exp_fc & 16'hFFFF));
    check("byte_count", byte_count, 32'(exp_bc));
`endif
  endtask

  function automatic int pick_avail(input int cnt);
    if ($urandom_range(0, 3) == 0) return $urandom_range(2, cnt + 3);
    return cnt + 4;
  endfunction

  initial begin
    int ncnt, navail, hold, w;
    bit started, ch;
    repeat (3) @(negedge clk);
    check("rst_tx_en", {31'd0, tx_en}, 32'd0);
    check("rst_txd", {28'd0, txd}, 32'd0);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_rd", {31'd0, fifo_rd}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    rst_n = 1'b1;

    // Fixed single-byte frame.
    prep_next(1, 5, 1'b1); raise_ready(); run_frame(3, 1'b0, 1'b0, 0, 0);
    // Ready held long: ack stays up and no second accept.
    prep_next(1, 5, 1'b0); raise_ready(); run_frame(60, 1'b0, 1'b0, 0, 0);
    // Underrun at the third read.
    prep_next(3, 2, 1'b0); raise_ready(); run_frame(2, 1'b0, 1'b0, 0, 0);
    // Back-to-back frames: exactly 24 idle cycles between them.
    prep_next(2, 6, 1'b0); raise_ready(); run_frame(2, 1'b0, 1'b1, 5, 9);
    run_frame(3, 1'b1, 1'b0, 0, 0);
    // CRC-only frame.
    prep_next(0, 4, 1'b0); raise_ready(); run_frame(1, 1'b0, 1'b0, 0, 0);

    // Random frames, some underrun, some chained.
    ncnt = $urandom_range(0, 30);
    prep_next(ncnt, pick_avail(ncnt), 1'b0);
    started = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (!started) raise_ready();
      ch = (nxt_avail >= nxt_cnt + 4) && (k < 9) && ($urandom_range(0, 1) == 1);
      ncnt = $urandom_range(0, 30);
      navail = pick_avail(ncnt);
      if (ch) navail = ncnt + 4;
      hold = $urandom_range(1, 12);
      run_frame(hold, started, ch, ncnt, navail);
      if (!ch) prep_next(ncnt, navail, 1'b0);
      started = ch;
    end
    fifo_q.delete();
    repeat (2) @(negedge clk);

    // Reset in the middle of payload transmission.
    prep_next(20, 24, 1'b0); raise_ready();
    w = 0;
    while (tx_en !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("rst_test_started", {31'd0, tx_en}, 32'd1);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    ready = 1'b0;
    @(negedge clk);
    check("midrst_tx_en", {31'd0, tx_en}, 32'd0);
    check("midrst_txd", {28'd0, txd}, 32'd0);
    check("midrst_ack", {31'd0, ack}, 32'd0);
    fifo_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_ur = 1'b0;
`ifdef ETH_TX_STATS_EN
    exp_fc = 0;
    exp_bc = 0;
`endif
    prep_next(0, 4, 1'b0); raise_ready(); run_frame(2, 1'b0, 1'b0, 0, 0);
    prep_next(60, 64, 1'b0); raise_ready(); run_frame(4, 1'b0, 1'b0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
